// File: rtl/ddr3_ram_arb.sv
// ddr3_ram_arb: N-port arbiter in front of a single ddr3_core request port.
// Requests from the AXI-to-RAM bridges are granted round-robin, tagged with
// the port index in the top four request-ID bits, and held in one output
// register until the core accepts them. Responses are routed back to the
// issuing port combinationally using that tag. A per-port counter limits
// how many requests a port may have in flight.
//
// Optional build macro: DDR3_RAM_ARB_PORT0_PRIO_EN
//   defined   -> port 0 has strict priority; ports 1..N-1 round-robin
//   undefined -> all ports share one round-robin
//
// Handshake semantics (both sides): a request is "valid" while its write
// mask is nonzero or its read strobe is high. Upstream, port_accept_o[p]
// is the ready for port p and the request transfers in the cycle where
// valid and ready are both high. Downstream, ram_wr_o/ram_rd_o are the
// valid and ram_accept_i is the ready; once valid is raised the request
// (mask, read, address, data, id) is held unchanged until ready is seen.
module ddr3_ram_arb #(
    parameter int NUM_PORTS       = 4,
    parameter int PORT_ID_W       = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PORTS*16-1:0]        port_wr_i,
    input  logic [NUM_PORTS-1:0]           port_rd_i,
    input  logic [NUM_PORTS*32-1:0]        port_addr_i,
    input  logic [NUM_PORTS*128-1:0]       port_write_data_i,
    input  logic [NUM_PORTS*PORT_ID_W-1:0] port_req_id_i,
    output logic [NUM_PORTS-1:0]           port_accept_o,
    output logic [NUM_PORTS-1:0]           port_ack_o,
    output logic [NUM_PORTS-1:0]           port_error_o,
    output logic [127:0]                   port_read_data_o,
    output logic [PORT_ID_W-1:0]           port_resp_id_o,
    output logic [31:0]                    ram_addr_o,
    output logic [15:0]                    ram_wr_o,
    output logic                           ram_rd_o,
    output logic [15:0]                    ram_req_id_o,
    output logic [127:0]                   ram_write_data_o,
    input  logic                           ram_accept_i,
    input  logic                           ram_ack_i,
    input  logic                           ram_error_i,
    input  logic [127:0]                   ram_read_data_i,
    input  logic [15:0]                    ram_resp_id_i
);

    // Port count and in-flight limit in the widths they are compared at.
    localparam logic [4:0] NP      = 5'(NUM_PORTS);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    // Eligibility is kept 16 wide so a 4-bit port index always selects in range.
    logic [15:0]          eligible;
    logic [3:0]           outstanding [NUM_PORTS];
    logic [NUM_PORTS-1:0] cnt_inc;
    logic [NUM_PORTS-1:0] cnt_dec;

    logic                 req_valid;
    logic                 reg_free;
    logic                 capture;
    logic [3:0]           rr_ptr;
    logic [3:0]           next_ptr;
    logic                 grant_valid;
    logic [3:0]           grant_idx;
    logic [4:0]           cand;
    logic [4:0]           rr_base;

    logic [15:0]          sel_wr;
    logic                 sel_rd;
    logic [31:0]          sel_addr;
    logic [127:0]         sel_data;
    logic [PORT_ID_W-1:0] sel_id;

    logic [3:0]           resp_port;

    // The register can take a new request when empty or when it empties this cycle.
    assign reg_free  = !req_valid || ram_accept_i;
    assign capture   = reg_free && grant_valid && !rst_i;
    assign resp_port = ram_resp_id_i[15:12];

    // A port is eligible when it has a request and room for one more in flight.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = ((|port_wr_i[p*16 +: 16]) || port_rd_i[p]) &&
                          (outstanding[p] < MAX_OUT);
        end
    end

`ifdef DDR3_RAM_ARB_PORT0_PRIO_EN
    // Port 0 first; otherwise round-robin over ports 1..N-1 starting at the pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 4'd0;
        cand        = 5'd0;
        rr_base     = (rr_ptr == 4'd0) ? 5'd1 : {1'b0, rr_ptr};
        if (eligible[0]) begin
            grant_valid = 1'b1;
            grant_idx   = 4'd0;
        end else begin
            for (int i = 0; i < NUM_PORTS - 1; i++) begin
                cand = rr_base + 5'(i);
                if (cand >= NP) begin
                    cand = cand - NP + 5'd1;
                end
                if (!grant_valid && eligible[cand[3:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[3:0];
                end
            end
        end
    end

    // Pointer follows the last round-robin winner and never lands on port 0.
    always_comb begin
        next_ptr = rr_ptr;
        if (grant_idx != 4'd0) begin
            if (({1'b0, grant_idx} + 5'd1) >= NP) begin
                next_ptr = 4'd1;
            end else begin
                next_ptr = grant_idx + 4'd1;
            end
        end
    end
`else
    // Round-robin over all ports starting at the pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 4'd0;
        cand        = 5'd0;
        rr_base     = {1'b0, rr_ptr};
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = rr_base + 5'(i);
            if (cand >= NP) begin
                cand = cand - NP;
            end
            if (!grant_valid && eligible[cand[3:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[3:0];
            end
        end
    end

    // Pointer moves to the port after the winner, wrapping at NUM_PORTS.
    always_comb begin
        next_ptr = rr_ptr;
        if (({1'b0, grant_idx} + 5'd1) >= NP) begin
            next_ptr = 4'd0;
        end else begin
            next_ptr = grant_idx + 4'd1;
        end
    end
`endif

    // Select the granted port's request and raise its accept.
    always_comb begin
        port_accept_o = '0;
        sel_wr        = '0;
        sel_rd        = 1'b0;
        sel_addr      = '0;
        sel_data      = '0;
        sel_id        = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == 4'(p)) begin
                sel_wr           = port_wr_i[p*16 +: 16];
                sel_rd           = port_rd_i[p];
                sel_addr         = port_addr_i[p*32 +: 32];
                sel_data         = port_write_data_i[p*128 +: 128];
                sel_id           = port_req_id_i[p*PORT_ID_W +: PORT_ID_W];
                port_accept_o[p] = capture;
            end
        end
    end

    // Output register toward the core, plus the round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid        <= 1'b0;
            ram_wr_o         <= '0;
            ram_rd_o         <= 1'b0;
            ram_addr_o       <= '0;
            ram_write_data_o <= '0;
            ram_req_id_o     <= '0;
            rr_ptr           <= '0;
        end else if (capture) begin
            // A write mask wins over a simultaneous read strobe.
            req_valid        <= 1'b1;
            ram_wr_o         <= sel_wr;
            ram_rd_o         <= sel_rd && !(|sel_wr);
            ram_addr_o       <= sel_addr;
            ram_write_data_o <= sel_data;
            ram_req_id_o     <= {grant_idx, sel_id};
            rr_ptr           <= next_ptr;
        end else if (ram_accept_i) begin
            req_valid        <= 1'b0;
            ram_wr_o         <= '0;
            ram_rd_o         <= 1'b0;
        end
    end

    // Per-port increment on capture and decrement on a counted ack.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_inc[p] = capture && (grant_idx == 4'(p));
            // Acks to a port with nothing in flight are forwarded but not counted.
            cnt_dec[p] = ram_ack_i && (resp_port == 4'(p)) &&
                         (outstanding[p] != 4'd0);
        end
    end

    // Outstanding counters; simultaneous increment and decrement cancel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                outstanding[p] <= 4'd0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (cnt_inc[p] && !cnt_dec[p]) begin
                    outstanding[p] <= outstanding[p] + 4'd1;
                end else if (cnt_dec[p] && !cnt_inc[p]) begin
                    outstanding[p] <= outstanding[p] - 4'd1;
                end
            end
        end
    end

    // Route responses by the port tag; tags beyond NUM_PORTS match no port.
    always_comb begin
        port_ack_o   = '0;
        port_error_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_ack_o[p]   = ram_ack_i && (resp_port == 4'(p));
            port_error_o[p] = ram_ack_i && (resp_port == 4'(p)) && ram_error_i;
        end
    end

    assign port_read_data_o = ram_read_data_i;
    assign port_resp_id_o   = ram_resp_id_i[PORT_ID_W-1:0];

endmodule

// File: tb/tb_ddr3_ram_arb.sv
// tb_ddr3_ram_arb: bench for ddr3_ram_arb with four ports. Expected core
// requests are pushed when a port is expected to be accepted and popped when
// the request appears on the ram_* outputs.
module tb_ddr3_ram_arb;

  localparam int NP   = 4;
  localparam int IDW  = 12;
  localparam int MAXO = 4;
  localparam int W    = 16 + 1 + 32 + 128 + 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP*16-1:0]    port_wr;
  logic [NP-1:0]       port_rd;
  logic [NP*32-1:0]    port_addr;
  logic [NP*128-1:0]   port_wdata;
  logic [NP*IDW-1:0]   port_id;
  logic [NP-1:0]       port_accept_o;
  logic [NP-1:0]       port_ack_o;
  logic [NP-1:0]       port_error_o;
  logic [127:0]        port_read_data_o;
  logic [IDW-1:0]      port_resp_id_o;
  logic [31:0]         ram_addr_o;
  logic [15:0]         ram_wr_o;
  logic                ram_rd_o;
  logic [15:0]         ram_req_id_o;
  logic [127:0]        ram_write_data_o;
  logic                ram_accept;
  logic                ram_ack;
  logic                ram_error;
  logic [127:0]        ram_rdata;
  logic [15:0]         ram_resp_id;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  ddr3_ram_arb #(
    .NUM_PORTS(NP),
    .PORT_ID_W(IDW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .port_wr_i(port_wr),
    .port_rd_i(port_rd),
    .port_addr_i(port_addr),
    .port_write_data_i(port_wdata),
    .port_req_id_i(port_id),
    .port_accept_o(port_accept_o),
    .port_ack_o(port_ack_o),
    .port_error_o(port_error_o),
    .port_read_data_o(port_read_data_o),
    .port_resp_id_o(port_resp_id_o),
    .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o),
    .ram_rd_o(ram_rd_o),
    .ram_req_id_o(ram_req_id_o),
    .ram_write_data_o(ram_write_data_o),
    .ram_accept_i(ram_accept),
    .ram_ack_i(ram_ack),
    .ram_error_i(ram_error),
    .ram_read_data_i(ram_rdata),
    .ram_resp_id_i(ram_resp_id)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic clear_ports();
    port_wr    = '0;
    port_rd    = '0;
    port_addr  = '0;
    port_wdata = '0;
    port_id    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_ports();
    ram_accept  = 1'b0;
    ram_ack     = 1'b0;
    ram_error   = 1'b0;
    ram_rdata   = '0;
    ram_resp_id = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 32'h000F_FFFF)) << 4;
  endfunction

  task automatic drive_port(input int p, input logic [15:0] wr, input logic rd,
                            input logic [31:0] addr, input logic [IDW-1:0] id);
    port_wr[p*16 +: 16]    = wr;
    port_rd[p]             = rd;
    port_addr[p*32 +: 32]  = addr;
    port_wdata[p*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    port_id[p*IDW +: IDW]  = id;
  endtask

  // Expected core request for port p, built from the stimulus the bench drives.
  function automatic logic [W-1:0] exp_entry(input int p);
    logic [15:0] wr;
    logic        rd;
    wr = port_wr[p*16 +: 16];
    rd = port_rd[p] & ~(|wr);
    return {wr, rd, port_addr[p*32 +: 32], port_wdata[p*128 +: 128], 4'(p), port_id[p*IDW +: IDW]};
  endfunction

  function automatic logic [W-1:0] obs();
    return {ram_wr_o, ram_rd_o, ram_addr_o, ram_write_data_o, ram_req_id_o};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int p = 0; p < NP; p++) drive_port(p, 16'h0, 1'b1, rand_addr(), 12'(p));
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b0000) $display("FAIL reset_accept: got %b exp %b", port_accept_o, 4'b0000);
    else pass_cnt++;
    @(negedge clk);
    clear_ports();
    rst = 1'b0;
    #1;
    check_cnt++;
    if (obs() !== '0) $display("FAIL reset_ram_out: got %h exp 0", obs());
    else pass_cnt++;
    check_cnt++;
    if (port_ack_o !== 4'b0000) $display("FAIL reset_ack: got %b exp 0000", port_ack_o);
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    do_reset();
    @(negedge clk);
    ram_accept = 1'b1;
    drive_port(2, 16'h00F0, 1'b0, 32'h100, 12'h005);
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b0100) $display("FAIL single_accept: got %b exp 0100", port_accept_o);
    else pass_cnt++;
    exp_q.push_back(exp_entry(2));
    @(negedge clk);
    clear_ports();
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b0000) $display("FAIL single_accept_drop: got %b exp 0000", port_accept_o);
    else pass_cnt++;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL single_req: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
    check_cnt++;
    if (ram_req_id_o !== 16'h2005 || ram_wr_o !== 16'h00F0)
      $display("FAIL single_id_mask: got id %h wr %h exp id 2005 wr 00f0", ram_req_id_o, ram_wr_o);
    else pass_cnt++;
    @(negedge clk);
    #1;
    check_cnt++;
    if (ram_wr_o !== 16'h0 || ram_rd_o !== 1'b0) $display("FAIL single_clear: got wr %h rd %b exp 0", ram_wr_o, ram_rd_o);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int order[5];
    logic [3:0] exp_acc;
`ifdef DDR3_RAM_ARB_PORT0_PRIO_EN
    order = '{0, 0, 0, 0, 1};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    @(negedge clk);
    ram_accept = 1'b1;
    for (int p = 0; p < NP; p++) drive_port(p, 16'h0, 1'b1, rand_addr(), 12'(12'h0A0 + p));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k > 0) begin
        exp_e = exp_q.pop_front();
        check_cnt++;
        if (obs() !== exp_e) $display("FAIL rr_req[%0d]: got %h exp %h", k, obs(), exp_e);
        else pass_cnt++;
      end
      exp_acc = 4'(1) << order[k];
      check_cnt++;
      if (port_accept_o !== exp_acc) $display("FAIL rr_accept[%0d]: got %b exp %b", k, port_accept_o, exp_acc);
      else pass_cnt++;
      exp_q.push_back(exp_entry(order[k]));
    end
    @(negedge clk);
    clear_ports();
    #1;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL rr_req_last: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    ram_accept = 1'b0;
    drive_port(1, 16'hFFFF, 1'b0, rand_addr(), 12'h111);
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b0010) $display("FAIL bp_first_accept: got %b exp 0010", port_accept_o);
    else pass_cnt++;
    exp_q.push_back(exp_entry(1));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        drive_port(1, 16'h00FF, 1'b0, rand_addr(), 12'h112);
        drive_port(3, 16'h3C00, 1'b1, rand_addr(), 12'h333);
      end
      #1;
      check_cnt++;
      if (port_accept_o !== 4'b0000) $display("FAIL bp_stall_accept[%0d]: got %b exp 0000", k, port_accept_o);
      else pass_cnt++;
      check_cnt++;
      if (obs() !== exp_q[0]) $display("FAIL bp_stable[%0d]: got %h exp %h", k, obs(), exp_q[0]);
      else pass_cnt++;
    end
    @(negedge clk);
    ram_accept = 1'b1;
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b1000) $display("FAIL bp_release_accept: got %b exp 1000", port_accept_o);
    else pass_cnt++;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL bp_release_req: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
    exp_q.push_back(exp_entry(3));
    @(negedge clk);
    clear_ports();
    #1;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL bp_wr_rd_req: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
  endtask

  task automatic test_outstanding();
    bit pending;
    logic [3:0] exp_acc;
    logic [127:0] rdata;
    do_reset();
    @(negedge clk);
    ram_accept = 1'b1;
    drive_port(1, 16'h0, 1'b1, rand_addr(), 12'h0C1);
    pending = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (pending) begin
        exp_e = exp_q.pop_front();
        check_cnt++;
        if (obs() !== exp_e) $display("FAIL os_req[%0d]: got %h exp %h", k, obs(), exp_e);
        else pass_cnt++;
      end else begin
        check_cnt++;
        if (ram_rd_o !== 1'b0 || ram_wr_o !== 16'h0) $display("FAIL os_idle[%0d]: got rd %b wr %h exp 0", k, ram_rd_o, ram_wr_o);
        else pass_cnt++;
      end
      exp_acc = (k < MAXO) ? 4'b0010 : 4'b0000;
      check_cnt++;
      if (port_accept_o !== exp_acc) $display("FAIL os_accept[%0d]: got %b exp %b", k, port_accept_o, exp_acc);
      else pass_cnt++;
      pending = (k < MAXO);
      if (pending) exp_q.push_back(exp_entry(1));
    end
    @(negedge clk);
    rdata = {$urandom, $urandom, $urandom, $urandom};
    ram_ack     = 1'b1;
    ram_resp_id = 16'h1003;
    ram_rdata   = rdata;
    #1;
    check_cnt++;
    if (port_ack_o !== 4'b0010) $display("FAIL os_ack: got %b exp 0010", port_ack_o);
    else pass_cnt++;
    check_cnt++;
    if (port_resp_id_o !== 12'h003) $display("FAIL os_resp_id: got %h exp 003", port_resp_id_o);
    else pass_cnt++;
    check_cnt++;
    if (port_read_data_o !== rdata) $display("FAIL os_rdata: got %h exp %h", port_read_data_o, rdata);
    else pass_cnt++;
    check_cnt++;
    if (port_error_o !== 4'b0000) $display("FAIL os_error: got %b exp 0000", port_error_o);
    else pass_cnt++;
    check_cnt++;
    if (port_accept_o !== 4'b0000) $display("FAIL os_ack_cycle_accept: got %b exp 0000", port_accept_o);
    else pass_cnt++;
    @(negedge clk);
    ram_ack = 1'b0;
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b0010) $display("FAIL os_after_ack_accept: got %b exp 0010", port_accept_o);
    else pass_cnt++;
    exp_q.push_back(exp_entry(1));
    @(negedge clk);
    clear_ports();
    #1;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL os_after_ack_req: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    bit pending;
    logic [3:0] exp_acc;
    do_reset();
    @(negedge clk);
    ram_accept = 1'b1;
    drive_port(3, 16'h0, 1'b1, rand_addr(), 12'h0D3);
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b1000) $display("FAIL sc_first_accept: got %b exp 1000", port_accept_o);
    else pass_cnt++;
    exp_q.push_back(exp_entry(3));
    @(negedge clk);
    ram_ack     = 1'b1;
    ram_resp_id = 16'h3007;
    ram_error   = 1'b1;
    #1;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL sc_req0: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
    check_cnt++;
    if (port_accept_o !== 4'b1000) $display("FAIL sc_both_accept: got %b exp 1000", port_accept_o);
    else pass_cnt++;
    check_cnt++;
    if (port_ack_o !== 4'b1000) $display("FAIL sc_both_ack: got %b exp 1000", port_ack_o);
    else pass_cnt++;
    check_cnt++;
    if (port_error_o !== 4'b1000) $display("FAIL sc_both_error: got %b exp 1000", port_error_o);
    else pass_cnt++;
    exp_q.push_back(exp_entry(3));
    pending = 1'b1;
    // Counter should still be 1 here, so three more captures fit before the limit.
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      ram_ack   = 1'b0;
      ram_error = 1'b0;
      #1;
      if (pending) begin
        exp_e = exp_q.pop_front();
        check_cnt++;
        if (obs() !== exp_e) $display("FAIL sc_req[%0d]: got %h exp %h", k, obs(), exp_e);
        else pass_cnt++;
      end
      exp_acc = (k <= 4) ? 4'b1000 : 4'b0000;
      check_cnt++;
      if (port_accept_o !== exp_acc) $display("FAIL sc_fill_accept[%0d]: got %b exp %b", k, port_accept_o, exp_acc);
      else pass_cnt++;
      pending = (k <= 4);
      if (pending) exp_q.push_back(exp_entry(3));
    end
    @(negedge clk);
    ram_ack     = 1'b1;
    ram_resp_id = 16'h9000;
    ram_error   = 1'b1;
    #1;
    check_cnt++;
    if (port_ack_o !== 4'b0000) $display("FAIL sc_oob_ack: got %b exp 0000", port_ack_o);
    else pass_cnt++;
    check_cnt++;
    if (port_error_o !== 4'b0000) $display("FAIL sc_oob_error: got %b exp 0000", port_error_o);
    else pass_cnt++;
    check_cnt++;
    if (port_accept_o !== 4'b0000) $display("FAIL sc_oob_accept: got %b exp 0000", port_accept_o);
    else pass_cnt++;
    @(negedge clk);
    clear_ports();
    ram_resp_id = 16'h0001;
    ram_error   = 1'b0;
    #1;
    check_cnt++;
    if (port_ack_o !== 4'b0001) $display("FAIL sc_zero_cnt_ack: got %b exp 0001", port_ack_o);
    else pass_cnt++;
    @(negedge clk);
    ram_ack = 1'b0;
    drive_port(0, 16'h0, 1'b1, rand_addr(), 12'h0E0);
    pending = 1'b0;
    // Port 0 must still take a full MAX_OUTSTANDING after the uncounted ack.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (pending) begin
        exp_e = exp_q.pop_front();
        check_cnt++;
        if (obs() !== exp_e) $display("FAIL sc_p0_req[%0d]: got %h exp %h", k, obs(), exp_e);
        else pass_cnt++;
      end
      exp_acc = (k < MAXO) ? 4'b0001 : 4'b0000;
      check_cnt++;
      if (port_accept_o !== exp_acc) $display("FAIL sc_p0_accept[%0d]: got %b exp %b", k, port_accept_o, exp_acc);
      else pass_cnt++;
      pending = (k < MAXO);
      if (pending) exp_q.push_back(exp_entry(0));
    end
    @(negedge clk);
    clear_ports();
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_acc;
    do_reset();
    @(negedge clk);
    ram_accept = 1'b0;
    drive_port(2, 16'h000F, 1'b0, rand_addr(), 12'h0F2);
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b0100) $display("FAIL rm_accept: got %b exp 0100", port_accept_o);
    else pass_cnt++;
    exp_q.push_back(exp_entry(2));
    @(negedge clk);
    clear_ports();
    #1;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL rm_pending_req: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_cnt++;
    if (ram_wr_o !== 16'h0 || ram_rd_o !== 1'b0 || ram_req_id_o !== 16'h0)
      $display("FAIL rm_discard: got wr %h rd %b id %h exp 0", ram_wr_o, ram_rd_o, ram_req_id_o);
    else pass_cnt++;
    ram_accept = 1'b1;
    for (int p = 0; p < NP; p++) drive_port(p, 16'h0, 1'b1, rand_addr(), 12'(12'h0B0 + p));
    #1;
    check_cnt++;
    if (port_accept_o !== 4'b0001) $display("FAIL rm_ptr_accept: got %b exp 0001", port_accept_o);
    else pass_cnt++;
    exp_q.push_back(exp_entry(0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      exp_e = exp_q.pop_front();
      check_cnt++;
      if (obs() !== exp_e) $display("FAIL rm_req[%0d]: got %h exp %h", k, obs(), exp_e);
      else pass_cnt++;
`ifdef DDR3_RAM_ARB_PORT0_PRIO_EN
      exp_acc = 4'b0001;
`else
      exp_acc = 4'(1) << k;
`endif
      check_cnt++;
      if (port_accept_o !== exp_acc) $display("FAIL rm_order[%0d]: got %b exp %b", k, port_accept_o, exp_acc);
      else pass_cnt++;
      exp_q.push_back(exp_entry((exp_acc == 4'b0001) ? 0 : k));
    end
    @(negedge clk);
    clear_ports();
    #1;
    exp_e = exp_q.pop_front();
    check_cnt++;
    if (obs() !== exp_e) $display("FAIL rm_req_last: got %h exp %h", obs(), exp_e);
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst         = 1'b1;
    ram_accept  = 1'b0;
    ram_ack     = 1'b0;
    ram_error   = 1'b0;
    ram_rdata   = '0;
    ram_resp_id = '0;
    clear_ports();
    test_reset();
    test_single_write();
    test_round_robin();
    test_backpressure();
    test_outstanding();
    test_same_cycle();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/ddr3_ram_arb.md
Name: ddr3_ram_arb

Overview:
- Parametrised N-port arbiter placed between several AXI-to-RAM bridges (ddr3_axi_pmem instances) and a single ddr3_core RAM request port.
- Lets multiple AXI masters share one DDR3 controller. Keeps per-port byte-mask partial writes intact.
- Tags each request with its port index in the upper request-ID bits, and uses those bits to route acks and read data back to the issuing port.
- Limits outstanding requests per port so no port can flood the core's response path.

Parameters:
- NUM_PORTS, 4, number of upstream request ports; legal range 2..16.
- PORT_ID_W, 12, per-port request ID width; must satisfy PORT_ID_W + 4 = 16.
- MAX_OUTSTANDING, 4, maximum un-acked requests per port; legal range 1..15.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- port_wr_i  input  NUM_PORTS*16  per-port write byte mask; nonzero means write request
- port_rd_i  input  NUM_PORTS  per-port read request
- port_addr_i  input  NUM_PORTS*32  per-port byte address
- port_write_data_i  input  NUM_PORTS*128  per-port write data
- port_req_id_i  input  NUM_PORTS*PORT_ID_W  per-port request ID
- port_accept_o  output  NUM_PORTS  request taken this cycle
- port_ack_o  output  NUM_PORTS  response strobe for that port
- port_error_o  output  NUM_PORTS  response error for that port
- port_read_data_o  output  128  shared read data, valid with port_ack_o
- port_resp_id_o  output  PORT_ID_W  shared response ID
- ram_addr_o  output  32  to core
- ram_wr_o  output  16  to core, byte mask
- ram_rd_o  output  1  to core
- ram_req_id_o  output  16  {port index[3:0], port req id}
- ram_write_data_o  output  128  to core
- ram_accept_i  input  1  core took request
- ram_ack_i  input  1  core response strobe
- ram_error_i  input  1  core response error
- ram_read_data_i  input  128  core read data
- ram_resp_id_i  input  16  core response ID

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values: all ram_* outputs 0, port_accept_o 0, round-robin pointer 0, all outstanding counters 0, output register invalid.
- Request eligibility: port p is eligible when (port_wr_i[p] != 0 or port_rd_i[p]) and outstanding[p] < MAX_OUTSTANDING.
- Both wr and rd on one port: treated as a write; rd is ignored and not forwarded.
- Output register: one entry holding the request presented to the core.
  - "Free" = the entry is invalid, or it is valid and ram_accept_i=1 in the same cycle.
  - When free and at least one port is eligible, the arbiter grants exactly one port, sets port_accept_o[grant]=1 (combinational), and captures that port's request into the output register on the clock edge.
  - Forward latency: port request to ram_* valid is 1 cycle.
- Ram-side handshake: ram_wr_o/ram_rd_o, once asserted, stay stable along with addr, data and id until ram_accept_i. Back-to-back capture on the accept cycle is allowed, giving 1 request per cycle of throughput.
- Grant order: round-robin starting at the pointer. After a capture, pointer = grant+1, wrapping at NUM_PORTS. Pointer does not move when nothing is captured.
- Non-grant outputs: port_accept_o is 0 for every non-granted port and 0 while the register is not free.
- Outstanding counter per port, width 4:
  - +1 on capture from that port.
  - -1 on ram_ack_i with ram_resp_id_i[15:12]==p.
  - Both in the same cycle: unchanged.
  - Never under- or overflows; an ack to a port whose counter is 0 is ignored for counting but still forwarded.
- Response path: combinational, zero latency.
  - port_ack_o[p] = ram_ack_i & (ram_resp_id_i[15:12]==p).
  - port_error_o[p] = port_ack_o[p] & ram_error_i.
  - port_read_data_o = ram_read_data_i; port_resp_id_o = ram_resp_id_i[PORT_ID_W-1:0].
- Out-of-range response: if ram_resp_id_i[15:12] >= NUM_PORTS, no port acks and the response is dropped.
- Reset mid-operation: a pending output entry is discarded. Counters are cleared, so responses that arrive after reset for pre-reset requests are routed but not counted.

Optional Feature:
- Macro: DDR3_RAM_ARB_PORT0_PRIO_EN.
- Defined: port 0 has strict priority; whenever port 0 is eligible and the register is free, port 0 is granted. Ports 1..N-1 round-robin among themselves, and the pointer skips port 0.
- Undefined: all ports are equal in the round-robin, as described above.

Test Plan:
- Single port 2 write, wr=16'h00F0, addr=32'h100, id=12'h005, ram_accept_i=1 → next cycle ram_wr_o=16'h00F0, ram_req_id_o=16'h2005; port_accept_o=4'b0100 for exactly one cycle.
- All 4 ports request reads continuously with ram_accept_i=1 → ram_req_id_o[15:12] sequence is 0,1,2,3,0 with one request per cycle.
- ram_accept_i held 0 for 5 cycles with a captured request → ram_* outputs stable; port_accept_o=0 throughout; first new capture occurs on the accept cycle.
- Port 1 issues 4 reads with no acks (MAX_OUTSTANDING=4) → the 5th is not accepted. Ack with ram_resp_id_i=16'h1003 → port_ack_o=4'b0010, port_resp_id_o=12'h003, and port 1 is accepted the following cycle.
- Capture from port 3 and an ack to port 3 in the same cycle → outstanding[3] unchanged. Ack with id 16'h9000 when NUM_PORTS=4 → port_ack_o=0.
- rst_i pulsed while a request is pending with ram_accept_i=0 → next cycle ram_wr_o=0, ram_rd_o=0, pointer 0; with the macro defined, port 0 wins over ports 1–3 on every free cycle.
